// File: rtl/data_path_muxs_pkg.sv
// data_path_muxs_pkg: shared types and constants for the pipeline datapath glue.
package data_path_muxs_pkg;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        HALTED
    } seq_state_t;

    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID-stage read of a register that the EX-stage load has not produced yet.
module load_use_detect (
    input  logic       dREN_ID_EX,
    input  logic [4:0] wsel_ID_EX,
    input  logic [4:0] Rs_IF_ID,
    input  logic [4:0] Rt_IF_ID,
    input  logic       uses_rt_IF_ID,
    output logic       hazard
);

    always_comb begin
        hazard = dREN_ID_EX & (wsel_ID_EX != 5'd0)
               & ((wsel_ID_EX == Rs_IF_ID) | (uses_rt_IF_ID & (wsel_ID_EX == Rt_IF_ID)));
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stage enable/flush, PC enable and gated cache requests for the 5-stage pipeline.
module pipeline_sequencer
    import data_path_muxs_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dREN_EX_MEM,
    input  logic        dWEN_EX_MEM,
    input  logic        halt_EX_MEM,
    input  logic        halt_MEM_WB,
    input  logic        dREN_ID_EX,
    input  logic [4:0]  wsel_ID_EX,
    input  logic [4:0]  Rs_IF_ID,
    input  logic [4:0]  Rt_IF_ID,
    input  logic        uses_rt_IF_ID,
    input  logic        branch_taken,
    output logic        enable_IF_ID,
    output logic        enable_ID_EX,
    output logic        enable_EX_MEM,
    output logic        enable_MEM_WB,
    output logic        flush_IF_ID,
    output logic        flush_ID_EX,
    output logic        flush_EX_MEM,
    output logic        flush_MEM_WB,
    output logic        pc_enable,
    output logic        imemREN,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic        halt,
    output logic [31:0] stall_cycles
);

    seq_state_t  state_q, state_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic        halt_q, halt_d;
    logic [31:0] stall_q, stall_d;
    logic        hazard, mem_req, halted, advance, redirect, bubble;

    load_use_detect u_lud (
        .dREN_ID_EX    (dREN_ID_EX),
        .wsel_ID_EX    (wsel_ID_EX),
        .Rs_IF_ID      (Rs_IF_ID),
        .Rt_IF_ID      (Rt_IF_ID),
        .uses_rt_IF_ID (uses_rt_IF_ID),
        .hazard        (hazard)
    );

    always_comb begin
        mem_req       = dREN_EX_MEM | dWEN_EX_MEM;
        halted        = state_q == HALTED;
        advance       = (ihit | i_done_q) & (~mem_req | dhit | d_done_q) & ~halted;
        redirect      = halt_EX_MEM | branch_taken;
        bubble        = advance & hazard & ~redirect;
        enable_IF_ID  = advance & ~bubble;
        enable_ID_EX  = advance;
        enable_EX_MEM = advance;
        enable_MEM_WB = advance;
        flush_IF_ID   = advance & redirect;
        flush_ID_EX   = advance & (redirect | hazard);
        flush_EX_MEM  = advance & halt_EX_MEM;
        flush_MEM_WB  = 1'b0;
        pc_enable     = advance & ~halt_EX_MEM & (branch_taken | ~hazard);
        imemREN       = ~halted & ~i_done_q & ~halt_EX_MEM;
        dmemREN       = dREN_EX_MEM & ~d_done_q & ~halted;
        dmemWEN       = dWEN_EX_MEM & ~d_done_q & ~halted;
        halt          = halt_q;
        stall_cycles  = stall_q;
        // Hits seen while held are remembered so the cache is not asked twice.
        i_done_d      = ~advance & ~halted & (i_done_q | ihit);
        d_done_d      = ~advance & ~halted & (d_done_q | dhit);
        state_d       = (halted | halt_MEM_WB) ? HALTED : advance ? RUN : WAIT;
        halt_d        = state_d == HALTED;
        stall_d       = stall_q + {31'd0, ~halted & (~advance | bubble) & (stall_q != STALL_MAX)};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= RUN;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            halt_q   <= 1'b0;
            stall_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
            halt_q   <= halt_d;
            stall_q  <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed vectors with a queued scoreboard checked by an independent monitor.
module tb_pipeline_sequencer;

    typedef struct packed {
        logic       rstn;
        logic       ihit;
        logic       dhit;
        logic       drm;
        logic       dwm;
        logic       hm;
        logic       hw;
        logic       drx;
        logic [4:0] wsel;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       br;
    } in_t;

    typedef struct packed {
        logic [3:0]  en;
        logic [3:0]  fl;
        logic        pc;
        logic        im;
        logic        dr;
        logic        dw;
        logic        h;
        logic [31:0] st;
    } exp_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0, dhit = 1'b0;
    logic        dREN_EX_MEM = 1'b0, dWEN_EX_MEM = 1'b0;
    logic        halt_EX_MEM = 1'b0, halt_MEM_WB = 1'b0;
    logic        dREN_ID_EX = 1'b0;
    logic [4:0]  wsel_ID_EX = 5'd0, Rs_IF_ID = 5'd0, Rt_IF_ID = 5'd0;
    logic        uses_rt_IF_ID = 1'b0, branch_taken = 1'b0;
    logic        enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB;
    logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
    logic        pc_enable, imemREN, dmemREN, dmemWEN, halt;
    logic [31:0] stall_cycles;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    string name_q[$];
    exp_t mon_e, mon_g;
    string mon_n;

    always #5 CLK = ~CLK;

    pipeline_sequencer dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .ihit          (ihit),
        .dhit          (dhit),
        .dREN_EX_MEM   (dREN_EX_MEM),
        .dWEN_EX_MEM   (dWEN_EX_MEM),
        .halt_EX_MEM   (halt_EX_MEM),
        .halt_MEM_WB   (halt_MEM_WB),
        .dREN_ID_EX    (dREN_ID_EX),
        .wsel_ID_EX    (wsel_ID_EX),
        .Rs_IF_ID      (Rs_IF_ID),
        .Rt_IF_ID      (Rt_IF_ID),
        .uses_rt_IF_ID (uses_rt_IF_ID),
        .branch_taken  (branch_taken),
        .enable_IF_ID  (enable_IF_ID),
        .enable_ID_EX  (enable_ID_EX),
        .enable_EX_MEM (enable_EX_MEM),
        .enable_MEM_WB (enable_MEM_WB),
        .flush_IF_ID   (flush_IF_ID),
        .flush_ID_EX   (flush_ID_EX),
        .flush_EX_MEM  (flush_EX_MEM),
        .flush_MEM_WB  (flush_MEM_WB),
        .pc_enable     (pc_enable),
        .imemREN       (imemREN),
        .dmemREN       (dmemREN),
        .dmemWEN       (dmemWEN),
        .halt          (halt),
        .stall_cycles  (stall_cycles)
    );

    function automatic exp_t ex(input logic [3:0] en, input logic [3:0] fl, input logic pc,
                                input logic im, input logic dr, input logic dw, input logic h,
                                input logic [31:0] st);
        ex = '{en: en, fl: fl, pc: pc, im: im, dr: dr, dw: dw, h: h, st: st};
    endfunction

    task automatic drive(input in_t i);
        nRST          = i.rstn;
        ihit          = i.ihit;
        dhit          = i.dhit;
        dREN_EX_MEM   = i.drm;
        dWEN_EX_MEM   = i.dwm;
        halt_EX_MEM   = i.hm;
        halt_MEM_WB   = i.hw;
        dREN_ID_EX    = i.drx;
        wsel_ID_EX    = i.wsel;
        Rs_IF_ID      = i.rs;
        Rt_IF_ID      = i.rt;
        uses_rt_IF_ID = i.ur;
        branch_taken  = i.br;
    endtask

    task automatic vec(input string n, input in_t i, input exp_t e);
        @(posedge CLK);
        #1;
        drive(i);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            mon_g = '{en: {enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB},
                      fl: {flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB},
                      pc: pc_enable, im: imemREN, dr: dmemREN, dw: dmemWEN, h: halt,
                      st: stall_cycles};
            checks++;
            if (mon_g !== mon_e) begin
                errors++;
                $display("FAIL %s: got en=%b fl=%b pc=%b im=%b dr=%b dw=%b h=%b st=%h, expected en=%b fl=%b pc=%b im=%b dr=%b dw=%b h=%b st=%h",
                         mon_n, mon_g.en, mon_g.fl, mon_g.pc, mon_g.im, mon_g.dr, mon_g.dw, mon_g.h, mon_g.st,
                         mon_e.en, mon_e.fl, mon_e.pc, mon_e.im, mon_e.dr, mon_e.dw, mon_e.h, mon_e.st);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec("reset", in_t'{default: 0}, ex(4'h0, 4'h0, 0, 1, 0, 0, 0, 32'd0));
        repeat (4) vec("run", in_t'{rstn: 1, ihit: 1, default: 0}, ex(4'hF, 4'h0, 1, 1, 0, 0, 0, 32'd0));
        vec("lu_rs", in_t'{rstn: 1, ihit: 1, drx: 1, wsel: 5, rs: 5, default: 0},
            ex(4'b0111, 4'b0100, 0, 1, 0, 0, 0, 32'd0));
        vec("lu_wsel0", in_t'{rstn: 1, ihit: 1, drx: 1, default: 0}, ex(4'hF, 4'h0, 1, 1, 0, 0, 0, 32'd1));
        vec("lu_rt", in_t'{rstn: 1, ihit: 1, drx: 1, wsel: 7, rs: 3, rt: 7, ur: 1, default: 0},
            ex(4'b0111, 4'b0100, 0, 1, 0, 0, 0, 32'd1));
        vec("no_rt", in_t'{rstn: 1, ihit: 1, drx: 1, wsel: 7, rs: 3, rt: 7, default: 0},
            ex(4'hF, 4'h0, 1, 1, 0, 0, 0, 32'd2));
        vec("sw_c0", in_t'{rstn: 1, ihit: 1, dwm: 1, default: 0}, ex(4'h0, 4'h0, 0, 1, 0, 1, 0, 32'd2));
        vec("sw_c1", in_t'{rstn: 1, dwm: 1, default: 0}, ex(4'h0, 4'h0, 0, 0, 0, 1, 0, 32'd3));
        vec("sw_c2", in_t'{rstn: 1, dwm: 1, dhit: 1, default: 0}, ex(4'hF, 4'h0, 1, 0, 0, 1, 0, 32'd4));
        vec("sw_c3", in_t'{rstn: 1, ihit: 1, default: 0}, ex(4'hF, 4'h0, 1, 1, 0, 0, 0, 32'd4));
        vec("ld_dhit", in_t'{rstn: 1, dhit: 1, drm: 1, default: 0}, ex(4'h0, 4'h0, 0, 1, 1, 0, 0, 32'd4));
        vec("ld_ddone", in_t'{rstn: 1, drm: 1, default: 0}, ex(4'h0, 4'h0, 0, 1, 0, 0, 0, 32'd5));
        vec("ld_ihit", in_t'{rstn: 1, ihit: 1, drm: 1, default: 0}, ex(4'hF, 4'h0, 1, 1, 0, 0, 0, 32'd6));
        vec("both_hit", in_t'{rstn: 1, ihit: 1, dhit: 1, drm: 1, default: 0}, ex(4'hF, 4'h0, 1, 1, 1, 0, 0, 32'd6));
        vec("br_lu", in_t'{rstn: 1, ihit: 1, br: 1, drx: 1, wsel: 5, rs: 5, default: 0},
            ex(4'hF, 4'b1100, 1, 1, 0, 0, 0, 32'd6));
        vec("after_br", in_t'{rstn: 1, ihit: 1, default: 0}, ex(4'hF, 4'h0, 1, 1, 0, 0, 0, 32'd6));
        vec("halt_mem", in_t'{rstn: 1, ihit: 1, hm: 1, br: 1, default: 0}, ex(4'hF, 4'b1110, 0, 0, 0, 0, 0, 32'd6));
        vec("halt_wb", in_t'{rstn: 1, ihit: 1, hw: 1, default: 0}, ex(4'hF, 4'h0, 1, 1, 0, 0, 0, 32'd6));
        repeat (10) vec("halted", in_t'{rstn: 1, ihit: 1, dhit: 1, drm: 1, dwm: 1, default: 0},
                        ex(4'h0, 4'h0, 0, 0, 0, 0, 1, 32'd6));
        vec("rst_from_halt", in_t'{default: 0}, ex(4'h0, 4'h0, 0, 1, 0, 0, 0, 32'd0));
        vec("halt_stall", in_t'{rstn: 1, hw: 1, default: 0}, ex(4'h0, 4'h0, 0, 1, 0, 0, 0, 32'd0));
        vec("halted_stall", in_t'{rstn: 1, default: 0}, ex(4'h0, 4'h0, 0, 0, 0, 0, 1, 32'd1));
        vec("rst2", in_t'{default: 0}, ex(4'h0, 4'h0, 0, 1, 0, 0, 0, 32'd0));
        vec("wait_c0", in_t'{rstn: 1, ihit: 1, dwm: 1, default: 0}, ex(4'h0, 4'h0, 0, 1, 0, 1, 0, 32'd0));
        vec("wait_c1", in_t'{rstn: 1, dwm: 1, default: 0}, ex(4'h0, 4'h0, 0, 0, 0, 1, 0, 32'd1));
        vec("rst_mid_wait", in_t'{dwm: 1, default: 0}, ex(4'h0, 4'h0, 0, 1, 0, 1, 0, 32'd0));
        @(posedge CLK);
        #1;
        drive(in_t'{rstn: 1, default: 0});
        force dut.stall_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_q;
        repeat (3) vec("sat", in_t'{rstn: 1, default: 0}, ex(4'h0, 4'h0, 0, 1, 0, 0, 0, 32'hFFFF_FFFF));
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses never checked", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Sequential replacement for the combinational pipeline controller of the 5-stage MIPS pipeline. It generates enable/flush for IF_ID, ID_EX, EX_MEM and MEM_WB, plus PC enable and gated cache requests. It covers instruction/data memory wait states, load-use bubbles, taken-branch/jump squash, and sticky halt. It sits beside the datapath glue, between the stage registers and datapath_cache_if.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset; asynchronous, active-low.
- ihit  in  1  instruction cache hit for current imemaddr.
- dhit  in  1  data cache hit for current MEM-stage access.
- dREN_EX_MEM, dWEN_EX_MEM  in  1 each  MEM-stage data read/write request.
- halt_EX_MEM  in  1  halt instruction in MEM stage.
- halt_MEM_WB  in  1  halt instruction in WB stage.
- dREN_ID_EX  in  1  EX-stage instruction is a load.
- wsel_ID_EX  in  5  EX-stage destination register.
- Rs_IF_ID, Rt_IF_ID  in  5 each  ID-stage source registers.
- uses_rt_IF_ID  in  1  ID-stage instruction reads Rt.
- branch_taken  in  1  EX stage redirects PC (taken branch, J, JAL, JR).
- enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  out  1 each  stage register load.
- flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each  stage register clear to bubble.
- pc_enable  out  1  PC may update.
- imemREN  out  1  instruction fetch request.
- dmemREN, dmemWEN  out  1 each  gated data request to cache.
- halt  out  1  sticky halt to system.
- stall_cycles  out  32  saturating count of lost cycles.

## Operation
- FSM states: RUN, WAIT, HALTED.
- Flag i_done is set when ihit=1 while the pipeline is held, and cleared on advance.
- Flag d_done is set when dhit=1 while the pipeline is held, and cleared on advance.
- mem_req = dREN_EX_MEM | dWEN_EX_MEM.
- advance = (ihit | i_done) & (~mem_req | dhit | d_done) & state≠HALTED.
- No advance: all enables and flushes are 0, pc_enable=0, state→WAIT.
- Advance with no hazard: all enables are 1, pc_enable=1, state→RUN.
- Load-use: advance & dREN_ID_EX & wsel_ID_EX≠0 & (wsel_ID_EX==Rs_IF_ID | (uses_rt_IF_ID & wsel_ID_EX==Rt_IF_ID)). Response:
  - enable_IF_ID=0, pc_enable=0.
  - flush_ID_EX=1.
  - EX_MEM and MEM_WB advance.
- Branch: advance & branch_taken gives flush_IF_ID=1, flush_ID_EX=1, pc_enable=1. Branch has priority over load-use.
- Halt in MEM: advance & halt_EX_MEM gives flush_IF_ID, flush_ID_EX and flush_EX_MEM all 1, and pc_enable=0. halt_EX_MEM has priority over branch and load-use.
- halt_MEM_WB=1 → state HALTED next edge.
- In HALTED:
  - All enables are 0, pc_enable=0.
  - imemREN, dmemREN and dmemWEN are 0.
  - halt=1.
  - HALTED exits only on reset.
- imemREN = (state≠HALTED) & ~i_done & ~halt_EX_MEM.
- dmemREN = dREN_EX_MEM & ~d_done & state≠HALTED. dmemWEN follows the same rule with dWEN_EX_MEM.
- stall_cycles increments by 1 each cycle that is not HALTED and either has no advance or has a load-use bubble. It saturates at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - state=RUN, i_done=0, d_done=0, stall_cycles=0, halt=0.
  - Outputs follow combinationally from these and the inputs.
- All enable/flush/pc_enable outputs are combinational from registered state plus same-cycle inputs (zero latency).
- State and flag updates are on the rising edge of CLK.
- Simultaneous ihit and dhit in the same cycle: advance; neither flag is set.
- ihit with mem_req pending and no dhit: i_done=1 and imemREN drops next cycle. The cache is never re-requested for the same fetch.
- dhit while ihit pending: d_done=1, and dmemREN/dmemWEN drop next cycle, so a store is not repeated.
- halt_MEM_WB together with a stall: HALTED is still entered.
- nRST mid-WAIT: flags clear immediately and the FSM returns to RUN.

## Structure
- Add `seq_state_t` (RUN, WAIT, HALTED) to data_path_muxs_pkg.
- One combinational sub-module, `load_use_detect`. Inputs: dREN_ID_EX, wsel_ID_EX, Rs_IF_ID, Rt_IF_ID, uses_rt_IF_ID. Output: `hazard`.

## Test plan
- Reset, then ihit=1 and no mem_req for 4 cycles → all enables=1, pc_enable=1, stall_cycles=0.
- lw to $5 in EX, ID reads Rs=$5, ihit=1 → enable_IF_ID=0, flush_ID_EX=1, pc_enable=0, stall_cycles=1. With wsel=0, no bubble.
- sw in MEM, ihit=1 in cycle 0, dhit=1 in cycle 2:
  - Cycles 0–1 hold.
  - i_done=1 from cycle 1, so imemREN=0.
  - Cycle 2 advances.
  - stall_cycles=2.
  - dmemWEN was asserted exactly cycles 0–2.
- branch_taken=1 with a load-use hazard present, advance → flush_IF_ID=1, flush_ID_EX=1, pc_enable=1, no bubble count.
- halt_EX_MEM then halt_MEM_WB → halt=1 the next cycle, all enables and requests 0 for 10 cycles. Pulse nRST → state RUN, halt=0.
- Force stall_cycles to 32'hFFFF_FFFE, then stall 3 cycles → holds 32'hFFFF_FFFF.
